// File: rtl/uart_buffered_transmitter.sv
// UART transmitter with an internal TX FIFO, baud prescaler and run-time
// selectable parity / stop-bit count. Frames are sent back-to-back, LSB first.
module uart_buffered_transmitter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PRESCALE_WIDTH-1:0]     prescale,
  input  logic                          parity_enable,
  input  logic                          parity_type,
  input  logic                          two_stop_bits,
  input  logic                          data_valid,
  input  logic [DATA_WIDTH-1:0]         parallel_data,
  output logic                          ready,
  output logic                          serial_data_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] DepthC  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LastBit = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and pointers
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head;

  assign ready = (count_q < DepthC);
  assign push  = data_valid && ready;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= parallel_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Frame state
  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] reload_q, reload_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      parity_q, parity_d;
  logic                      par_en_q, par_en_d;
  logic                      two_stop_q, two_stop_d;
  logic                      serial_q, serial_d;
  logic                      tick, load;
  logic [PRESCALE_WIDTH-1:0] load_reload;

  assign tick        = (cnt_q == '0);
  assign load_reload = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = tick ? cnt_q : cnt_q - PRESCALE_WIDTH'(1);
    reload_d   = reload_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    load       = 1'b0;
    pop        = 1'b0;
    serial_d   = 1'b1;

    case (state_q)
      StIdle: begin
        if (count_q != '0) load = 1'b1;
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          bit_d   = '0;
          cnt_d   = reload_q;
        end
      end
      StData: begin
        if (tick) begin
          cnt_d = reload_q;
          if (bit_q == LastBit) begin
            state_d = par_en_q ? StParity : StStop;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d = StStop;
          bit_d   = '0;
          cnt_d   = reload_q;
        end
      end
      StStop: begin
        if (tick) begin
          // bit_q marks which stop bit is on the line
          if (two_stop_q && (bit_q == '0)) begin
            bit_d = BW'(1);
            cnt_d = reload_q;
          end else if (count_q != '0) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d    = StStart;
      pop        = 1'b1;
      shift_d    = head;
      reload_d   = load_reload;
      cnt_d      = load_reload;
      bit_d      = '0;
      parity_d   = parity_type ? ~^head : ^head;
      par_en_d   = parity_enable;
      two_stop_d = two_stop_bits;
    end

    // Line value is registered from the next state so it changes on the edge itself
    case (state_d)
      StStart:  serial_d = 1'b0;
      StData:   serial_d = shift_d[0];
      StParity: serial_d = parity_d;
      default:  serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      reload_q   <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      serial_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      serial_q   <= serial_d;
    end
  end

  assign serial_data_out = serial_q;
  assign busy            = (state_q != StIdle);
  assign fifo_count      = count_q;

endmodule

// File: tb/tb_uart_buffered_transmitter.sv
// Self-checking bench: expected line waveform is built per frame from the
// frame format and compared every cycle against serial_data_out and busy.
module tb_uart_buffered_transmitter;

  localparam int DW = 8;
  localparam int FD = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic          parity_enable = 1'b0;
  logic          parity_type = 1'b0;
  logic          two_stop_bits = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] parallel_data = '0;
  logic          ready;
  logic          serial_data_out;
  logic          busy;
  logic [2:0]    fifo_count;

  int checks = 0;
  int passes = 0;
  bit exp_q[$];

  int cur_p;
  bit cur_pe, cur_pt, cur_ts;

  uart_buffered_transmitter #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .clk(clk),
    .reset(reset_n),
    .prescale(prescale),
    .parity_enable(parity_enable),
    .parity_type(parity_type),
    .two_stop_bits(two_stop_bits),
    .data_valid(data_valid),
    .parallel_data(parallel_data),
    .ready(ready),
    .serial_data_out(serial_data_out),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected line samples for one frame, one entry per clock cycle
  function automatic void add_frame(input logic [DW-1:0] w);
    bit bits[$];
    int pp;
    int ones;
    pp   = (cur_p == 0) ? 1 : cur_p;
    ones = $countones(w);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
    if (cur_pe) bits.push_back(cur_pt ? (ones % 2 == 0) : (ones % 2 == 1));
    bits.push_back(1'b1);
    if (cur_ts) bits.push_back(1'b1);
    foreach (bits[i]) repeat (pp) exp_q.push_back(bits[i]);
  endfunction

  task automatic setcfg(input int p, input bit pe, input bit pt, input bit ts);
    cur_p = p; cur_pe = pe; cur_pt = pt; cur_ts = ts;
    prescale = PW'(p); parity_enable = pe; parity_type = pt; two_stop_bits = ts;
  endtask

  task automatic tick_check(input string tag);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      chk({tag, ".line"}, serial_data_out, exp_q.pop_front());
      chk({tag, ".busy"}, busy, 1);
    end else begin
      chk({tag, ".idle_line"}, serial_data_out, 1);
      chk({tag, ".idle_busy"}, busy, 0);
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      tick_check(tag);
      guard++;
    end
    chk({tag, ".drained"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) tick_check({tag, ".after"});
  endtask

  task automatic push_single(input logic [DW-1:0] w, input string tag);
    data_valid = 1'b1;
    parallel_data = w;
    tick_check(tag);
    chk({tag, ".count1"}, fifo_count, 1);
    data_valid = 1'b0;
    add_frame(w);
    tick_check(tag);
    chk({tag, ".count0"}, fifo_count, 0);
    drain(tag);
  endtask

  initial begin
    int exp_cnt;
    int n;
    logic [DW-1:0] w;

    // Reset state
    #12;
    chk("rst.line", serial_data_out, 1);
    chk("rst.busy", busy, 0);
    chk("rst.ready", ready, 1);
    chk("rst.count", fifo_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) tick_check("idle");

    setcfg(1, 1, 0, 0);
    push_single(8'hE6, "even");

    setcfg(1, 1, 1, 0);
    push_single(8'hFF, "odd");

    setcfg(1, 0, 0, 1);
    push_single(8'hF4, "stop2");

    // P=4 frame; prescale change mid-frame must not affect it
    setcfg(4, 1, 0, 0);
    data_valid = 1'b1;
    parallel_data = 8'hA5;
    tick_check("p4");
    data_valid = 1'b0;
    add_frame(8'hA5);
    chk("p4.len", exp_q.size(), 44);
    repeat (6) tick_check("p4");
    prescale = 16'd2;
    drain("p4");

    // Back-to-back: 0x01 pops at edge 2, so 0x06 meets a full FIFO at edge 6
    setcfg(1, 1, 0, 0);
    data_valid = 1'b1;
    parallel_data = 8'h01;
    tick_check("b2b");
    for (int i = 1; i <= 5; i++) add_frame(DW'(i));
    for (int i = 2; i <= 6; i++) begin
      parallel_data = DW'(i);
      tick_check("b2b");
      chk("b2b.count", fifo_count, (i <= 5) ? i - 1 + (i == 2 ? 0 : 0) : 4);
      chk("b2b.ready", ready, (i >= 5) ? 0 : 1);
    end
    data_valid = 1'b0;
    for (int e = 7; e <= 58; e++) begin
      tick_check("b2b");
      exp_cnt = 4 - int'(e >= 13) - int'(e >= 24) - int'(e >= 35) - int'(e >= 46);
      chk("b2b.count_dec", fifo_count, exp_cnt);
    end
    chk("b2b.only_accepted", exp_q.size(), 0);
    exp_q.delete();

    // Reset during DATA of 0x3C with two more words queued
    setcfg(2, 1, 0, 0);
    data_valid = 1'b1;
    parallel_data = 8'h3C;
    tick_check("rmid");
    add_frame(8'h3C);
    parallel_data = 8'h11;
    tick_check("rmid");
    parallel_data = 8'h22;
    tick_check("rmid");
    data_valid = 1'b0;
    repeat (2) tick_check("rmid");
    chk("rmid.pre_count", fifo_count, 2);
    reset_n = 1'b0;
    #1;
    chk("rmid.line", serial_data_out, 1);
    chk("rmid.busy", busy, 0);
    chk("rmid.count", fifo_count, 0);
    chk("rmid.ready", ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) tick_check("rmid.quiet");
    chk("rmid.count_after", fifo_count, 0);

    // Randomized frames, including prescale=0 and short bursts
    for (int it = 0; it < 10; it++) begin
      setcfg($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      n = $urandom_range(1, 3);
      data_valid = 1'b1;
      for (int j = 0; j < n; j++) begin
        w = DW'($urandom);
        parallel_data = w;
        tick_check("rand");
        add_frame(w);
      end
      data_valid = 1'b0;
      drain("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
